// File: rtl/j1_intc.sv
// Interrupt controller for the j1 core: synchronises request lines, latches edge
// events, applies mask and fixed priority, and exposes control through IO registers.
module j1_intc #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [15:0] VEC_BASE  = 16'h5DF8,
  parameter logic [15:0] ADDR_BASE = 16'h0100
) (
  input  logic               clk,
  input  logic               resetq,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_req,
  output logic [15:0]        irq_insn,
  input  logic               irq_taken,
  input  logic [15:0]        io_addr,
  input  logic [15:0]        io_wdata,
  input  logic               io_wr,
  input  logic               io_rd,
  output logic [15:0]        io_rdata
);

  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 16;

  logic [NUM_IRQ-1:0] s1, s2, s3;
  logic [NUM_IRQ-1:0] pend_q, mask_q, mode_q;
  logic [NUM_IRQ-1:0] pend_d, pend_vis, active, rise, clr, mode_chg, taken_vec, wdata_n;
  logic [SEL_W-1:0]   sel;
  logic               hit, wr_pend, wr_mask, wr_mode;
  logic [1:0]         reg_sel;
  logic               unused_ok;

  assign hit      = (io_addr[15:3] == ADDR_BASE[15:3]);
  assign reg_sel  = io_addr[2:1];
  assign wdata_n  = io_wdata[NUM_IRQ-1:0];
  assign wr_pend  = io_wr && hit && (reg_sel == 2'd0);
  assign wr_mask  = io_wr && hit && (reg_sel == 2'd1);
  assign wr_mode  = io_wr && hit && (reg_sel == 2'd2);
  assign unused_ok = ^{io_addr[0], io_wdata};

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Level channels follow the synchronised line; edge channels use the latch
  assign pend_vis = (mode_q & pend_q) | (~mode_q & s2);
  assign active   = pend_vis & mask_q;
  assign irq_req  = |active;

  // Highest set index wins
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (active[i]) sel = SEL_W'(i);
    end
  end

  assign irq_insn  = irq_req ? (VEC_BASE + DATA_W'(sel)) : '0;
  assign taken_vec = (irq_taken && irq_req) ? (NUM_IRQ'(1) << sel) : '0;

  // A fresh edge outranks clears; a mode change drops the latched state
  assign rise     = s2 & ~s3 & mode_q;
  assign clr      = taken_vec | (wr_pend ? wdata_n : '0);
  assign mode_chg = wr_mode ? (wdata_n ^ mode_q) : '0;
  assign pend_d   = ((pend_q & ~clr) | rise) & mode_q & ~mode_chg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_mask) mask_q <= wdata_n;
      if (wr_mode) mode_q <= wdata_n;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_rd && hit) begin
      case (reg_sel)
        2'd0:    io_rdata = DATA_W'(pend_vis);
        2'd1:    io_rdata = DATA_W'(mask_q);
        2'd2:    io_rdata = DATA_W'(mode_q);
        default: io_rdata = {irq_req, 10'b0, sel};
      endcase
    end
  end

endmodule

// File: tb/tb_j1_intc.sv
// Bench for j1_intc: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the controller's register semantics.
module tb_j1_intc;

  localparam int unsigned N = 8;

  logic          clk = 1'b0;
  logic          resetq;
  logic [N-1:0]  irq_in;
  logic          irq_req, irq_taken, io_wr, io_rd;
  logic [15:0]   irq_insn, io_addr, io_wdata, io_rdata;

  logic [15:0]   b_irq;
  logic          b_req, b_taken, b_wr, b_rd;
  logic [15:0]   b_insn, b_addr, b_wdata, b_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  j1_intc dut (
    .clk(clk), .resetq(resetq), .irq_in(irq_in), .irq_req(irq_req),
    .irq_insn(irq_insn), .irq_taken(irq_taken), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd), .io_rdata(io_rdata)
  );

  j1_intc #(.NUM_IRQ(16), .VEC_BASE(16'h5DF0), .ADDR_BASE(16'h0100)) dut16 (
    .clk(clk), .resetq(resetq), .irq_in(b_irq), .irq_req(b_req),
    .irq_insn(b_insn), .irq_taken(b_taken), .io_addr(b_addr),
    .io_wdata(b_wdata), .io_wr(b_wr), .io_rd(b_rd), .io_rdata(b_rdata)
  );

  // Model: h0/h1/h2 are input samples taken at the last three clock edges
  logic [N-1:0] h0, h1, h2, m_pend, m_mask, m_mode;

  function automatic void m_reset();
    h0 = '0; h1 = '0; h2 = '0; m_pend = '0; m_mask = '0; m_mode = '0;
  endfunction

  function automatic logic [N-1:0] m_vis();
    return (m_mode & m_pend) | (~m_mode & h1);
  endfunction

  function automatic logic m_req();
    return |(m_vis() & m_mask);
  endfunction

  function automatic int m_sel();
    logic [N-1:0] a;
    a = m_vis() & m_mask;
    for (int i = N - 1; i >= 0; i--) if (a[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] m_insn();
    return m_req() ? 16'h5DF8 + 16'(m_sel()) : 16'h0000;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a[15:3] != 13'h0020) return 16'h0000;
    case (a[2:1])
      2'd0:    return 16'(m_vis());
      2'd1:    return 16'(m_mask);
      2'd2:    return 16'(m_mode);
      default: return {m_req(), 10'b0, 5'(m_sel())};
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_req"}, 16'(irq_req), 16'(m_req()));
    check({tag, "_insn"}, irq_insn, m_insn());
  endtask

  // Advance one clock edge, updating the model from inputs held before the edge
  task automatic cycle();
    logic [N-1:0] smp, rise, clr, chg, nmask, nmode, npend;
    int s;
    smp   = irq_in;
    s     = m_sel();
    rise  = h1 & ~h2 & m_mode;
    clr   = '0;
    chg   = '0;
    nmask = m_mask;
    nmode = m_mode;
    if (irq_taken && m_req()) clr[s] = 1'b1;
    if (io_wr && io_addr[15:3] == 13'h0020) begin
      case (io_addr[2:1])
        2'd0: clr = clr | io_wdata[N-1:0];
        2'd1: nmask = io_wdata[N-1:0];
        2'd2: begin nmode = io_wdata[N-1:0]; chg = nmode ^ m_mode; end
        default: ;
      endcase
    end
    npend = ((m_pend & ~clr) | rise) & m_mode & ~chg;
    @(posedge clk);
    #1;
    if (!resetq) m_reset();
    else begin
      m_pend = npend; m_mask = nmask; m_mode = nmode;
      h2 = h1; h1 = h0; h0 = smp;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    cycle();
    io_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    io_addr = a; io_rd = 1'b1;
    #1;
    check(tag, io_rdata, exp);
    check({tag, "_mdl"}, io_rdata, m_read(a));
    io_rd = 1'b0;
  endtask

  task automatic take();
    irq_taken = 1'b1;
    cycle();
    irq_taken = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    int op;
    resetq = 1'b0; irq_in = '0; irq_taken = 1'b0;
    io_addr = '0; io_wdata = '0; io_wr = 1'b0; io_rd = 1'b0;
    b_irq = '0; b_taken = 1'b0; b_addr = '0; b_wdata = '0; b_wr = 1'b0; b_rd = 1'b0;
    m_reset();

    // Reset state
    rd_chk("rst_pend", 16'h0100, 16'h0000);
    rd_chk("rst_mask", 16'h0102, 16'h0000);
    rd_chk("rst_mode", 16'h0104, 16'h0000);
    rd_chk("rst_stat", 16'h0106, 16'h0000);
    check("rst_req", 16'(irq_req), 16'h0000);
    check("rst_insn", irq_insn, 16'h0000);
    @(posedge clk); #1;
    resetq = 1'b1;

    // Masked channel never raises a request
    irq_in[3] = 1'b1;
    cycle();
    irq_in[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("masked_req", 16'(irq_req), 16'h0000);
    end

    // Edge latency on channel 2
    wr(16'h0102, 16'h00FF);
    wr(16'h0104, 16'h00FF);
    cycle(); cycle(); cycle();
    irq_in[2] = 1'b1;
    cycle(); check("lat_e1", 16'(irq_req), 16'h0000);
    cycle(); check("lat_e2", 16'(irq_req), 16'h0000);
    cycle(); check("lat_e3", 16'(irq_req), 16'h0001);
    check("lat_insn", irq_insn, 16'h5DFA);
    rd_chk("lat_stat", 16'h0106, 16'h8002);
    take();
    check("take2_req", 16'(irq_req), 16'h0000);
    irq_in = '0;

    // Priority order across channels 7, 5, 1
    irq_in = 8'hA2;
    cycle(); cycle(); cycle();
    check("prio_7", irq_insn, 16'h5DFF);
    take(); check("prio_5", irq_insn, 16'h5DFD);
    take(); check("prio_1", irq_insn, 16'h5DF9);
    take(); check("prio_none", 16'(irq_req), 16'h0000);
    check_out("prio_mdl");
    irq_in = '0;

    // Level channel 4 survives irq_taken until the line drops
    wr(16'h0104, 16'h00EF);
    irq_in[4] = 1'b1;
    cycle(); check("lvl_k", 16'(irq_req), 16'h0000);
    cycle(); check("lvl_k1", 16'(irq_req), 16'h0001);
    check("lvl_insn", irq_insn, 16'h5DFC);
    take();
    rd_chk("lvl_pend", 16'h0100, 16'h0010);
    irq_in[4] = 1'b0;
    cycle(); check("lvl_drop1", 16'(irq_req), 16'h0001);
    cycle(); check("lvl_drop2", 16'(irq_req), 16'h0000);

    // New edge beats a simultaneous W1C; plain W1C clears
    wr(16'h0104, 16'h00FF);
    irq_in[2] = 1'b1;
    cycle(); cycle(); cycle();
    rd_chk("w1c_pre", 16'h0100, 16'h0004);
    irq_in[2] = 1'b0;
    cycle(); cycle(); cycle();
    irq_in[2] = 1'b1;
    cycle(); cycle();
    wr(16'h0100, 16'h0004);
    rd_chk("w1c_edge", 16'h0100, 16'h0004);
    wr(16'h0100, 16'h0004);
    rd_chk("w1c_clear", 16'h0100, 16'h0000);

    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        resetq = 1'b0;
        m_reset();
        #1;
        check_out("rst_mid");
        cycle();
        resetq = 1'b1;
      end
      irq_in = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      io_wr = 1'b0; irq_taken = 1'b0;
      a = 16'h0100 + 16'($urandom_range(0, 3) * 2) + 16'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      op = $urandom_range(0, 9);
      io_addr = a; io_rd = 1'b1; io_wdata = 16'($urandom);
      if (op < 2) io_wr = 1'b1;
      else if (op < 5) irq_taken = 1'b1;
      #1;
      check_out("rnd");
      check("rnd_rdata", io_rdata, m_read(a));
      cycle();
    end
    io_wr = 1'b0; io_rd = 1'b0; irq_taken = 1'b0; irq_in = '0;

    // 16-channel instance: top channel vector and out-of-window read
    b_addr = 16'h0102; b_wdata = 16'hFFFF; b_wr = 1'b1; cycle();
    b_addr = 16'h0104; cycle();
    b_wr = 1'b0;
    b_irq[15] = 1'b1;
    cycle(); cycle(); cycle();
    check("w16_req", 16'(b_req), 16'h0001);
    check("w16_insn", b_insn, 16'h5DFF);
    b_addr = 16'h0102; b_rd = 1'b1; #1;
    check("w16_mask", b_rdata, 16'hFFFF);
    b_addr = 16'h0200; #1;
    check("w16_miss", b_rdata, 16'h0000);
    b_rd = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/j1_intc.md
# j1_intc

Parametrised interrupt controller for the j1 core, replacing the fixed 8-input priority encoder built into the core. It synchronises NUM_IRQ asynchronous request lines, latches edge-mode events, and applies per-channel masking and fixed priority (highest index wins). It presents the core with a request flag and a ready-made call instruction, and clears the serviced channel on the core's accept strobe. Software controls it through four IO-mapped registers on the core's IO bus.

## Interface
- NUM_IRQ, 8: number of request channels, 1..16
- VEC_BASE, 16'h5DF8: call instruction issued for channel 0; channel i issues VEC_BASE + i
- ADDR_BASE, 16'h0100: IO base address; register window is ADDR_BASE..ADDR_BASE+7, 8-byte aligned
- clk  in  1  core clock
- resetq  in  1  asynchronous active-low reset
- irq_in  in  NUM_IRQ  raw request lines, asynchronous to clk
- irq_req  out  1  unmasked pending request exists
- irq_insn  out  16  call instruction for the highest-priority pending unmasked channel; 16'h0000 when irq_req=0
- irq_taken  in  1  core accepted the interrupt this cycle (request AND global enable)
- io_addr  in  16  IO address (core st0)
- io_wdata  in  16  IO write data (core st1)
- io_wr  in  1  IO write strobe, single cycle
- io_rd  in  1  IO read strobe, single cycle
- io_rdata  out  16  read data, combinational; 0 unless io_rd=1 and address hits the window

## Operation
- Reset: resetq asynchronous, active-low; clock clk. Sync/edge flops, PENDING, MASK, MODE all clear; irq_req=0, irq_insn=0, io_rdata=0.
- Per channel: two-flop synchroniser s1->s2, plus s3 = delayed s2.
- MODE bit i = 1 (edge): PENDING[i] set on s2 & ~s3. MODE bit i = 0 (level): PENDING[i] = s2, not latched.
- Active = PENDING & MASK. irq_req = |Active. sel = highest set index of Active. irq_insn = VEC_BASE + sel.
- irq_taken with irq_req=1: clear PENDING[sel] if channel sel is edge mode. Level channels are unaffected; the peripheral must drop its line. irq_taken with irq_req=0 is ignored.
- Register select: io_addr[15:3] == ADDR_BASE[15:3], with io_addr[2:1] choosing the register. Bits above NUM_IRQ read 0 and ignore writes.
  - 0 PENDING: read; write-1-to-clear for edge channels, no effect on level channels
  - 1 MASK: read/write
  - 2 MODE: read/write. Changing a channel edge->level or level->edge clears its latched PENDING in the same write.
  - 3 STATUS: read {irq_req, 10'b0, sel[4:0]} (sel=0 when no request); writes ignored
- Simultaneous events on one channel in one cycle: a new edge beats both W1C and irq_taken, so PENDING stays 1. A MASK write takes effect on irq_req the cycle after the write.

## Timing
- irq_in rises before edge k: s1=1 at k, s2=1 at k+1, PENDING set at k+2, irq_req high after k+2 (level mode: s2 drives PENDING directly, irq_req high after k+1).
- irq_req and irq_insn are combinational from registered state. No logic path from irq_taken to them, so there is no loop with the core.
- irq_taken at edge t: PENDING[sel] is 0 after t, and irq_req/irq_insn reflect the next channel in the following cycle.
- Register writes commit at the clock edge with io_wr=1. Reads return current register state combinationally in the io_rd cycle.
- Reset asserted mid-sequence: all state clears immediately. Edges already in the synchroniser are lost. After release, a line still held high re-triggers only in level mode.

## Test plan
- Reset, NUM_IRQ=8: all regs read 0, irq_req=0; pulse irq_in[3] with MASK=0 -> irq_req stays 0.
- MASK=8'hFF, MODE=8'hFF, rising edge on irq_in[2] -> irq_req=1 exactly 3 edges later, irq_insn=16'h5DFA, STATUS=16'h8002.
- Edges on channels 1, 5, 7 together -> irq_insn 16'h5DFF; irq_taken -> 16'h5DFD; irq_taken -> 16'h5DF9; irq_taken -> irq_req=0.
- Level channel 4 held high, irq_taken pulsed -> PENDING[4] stays 1; drop irq_in[4] -> irq_req=0 two cycles later.
- Write PENDING=16'h0004 in the same cycle a new edge on channel 2 is detected -> PENDING[2] remains 1. Separately, W1C with no edge -> PENDING[2]=0.
- NUM_IRQ=16, VEC_BASE=16'h5DF0: edge on channel 15 -> irq_insn=16'h5DFF; io_rd outside the window -> io_rdata=0.
